// File: rtl/lstm_accel_pkg.sv
// Shared definitions for the LSTM accelerator's A-matrix feed path.
//   a_feed_state_t : sequencer FSM states
//   A_WORD_W       : width of one skewed diagonal word (8 rows x 8 bits)
//   WAVE_IDX_W     : width of the wave index sent to the extractor
//   num_waves(n)   : number of skewed waves for an n x n pass (2n-1)
package lstm_accel_pkg;

    localparam int A_WORD_W   = 64;
    localparam int WAVE_IDX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } a_feed_state_t;

    function automatic int num_waves(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/a_feed_sequencer_fifo.sv
// a_feed_fifo: synchronous first-word-fall-through FIFO.
// The head entry is visible on 'head' whenever not_empty is high; it reads
// as all-zero while empty so downstream never sees stale storage.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry (caller guarantees not full)
//   pop             retire the head entry (caller guarantees not empty)
//   head            current head entry
//   not_empty       FIFO holds at least one entry
//   count           number of entries held, 0..DEPTH
module a_feed_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign not_empty = (count != '0);
    assign head      = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/a_feed_sequencer.sv
// a_feed_sequencer: walks the A-matrix extractor through every skewed wave
// (0 .. 2N-2) of one systolic pass, buffers each returned diagonal word in a
// small FWFT FIFO and streams it to the array's A-row input (valid/ready).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start / busy / done      pass request, pass in progress, end-of-pass pulse
//   ext_start / ext_cycle    extraction request and wave index to extractor
//   ext_a_flat / ext_valid   returned diagonal word and its strobe
//   a_tdata/a_tvalid/a_tready/a_tlast  downstream stream (tlast = last wave)
// Optional build macro A_FEED_PERF_EN adds stall_cycles and issue_stalls
// saturating performance counters.
module a_feed_sequencer
    import lstm_accel_pkg::*;
#(
    parameter int N          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ext_start,
    output logic [WAVE_IDX_W-1:0] ext_cycle,
    input  logic [A_WORD_W-1:0]   ext_a_flat,
    input  logic                  ext_valid,
    output logic [A_WORD_W-1:0]   a_tdata,
    output logic                  a_tvalid,
    input  logic                  a_tready,
    output logic                  a_tlast
`ifdef A_FEED_PERF_EN
    ,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           issue_stalls
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WAVE_IDX_W-1:0] LAST_WAVE = WAVE_IDX_W'(num_waves(N) - 1);
    localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);

    a_feed_state_t         state;
    logic [WAVE_IDX_W-1:0] wave_cnt;
    logic [CW-1:0]         fifo_count;
    logic [A_WORD_W:0]     head;
    logic                  push;
    logic                  pop;

    // Responses are only accepted while one is outstanding.
    assign push      = (state == S_WAIT) && ext_valid;
    assign pop       = a_tvalid && a_tready;
    assign ext_cycle = wave_cnt;

    a_feed_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (A_WORD_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({wave_cnt == LAST_WAVE, ext_a_flat}),
        .pop       (pop),
        .head      (head),
        .not_empty (a_tvalid),
        .count     (fifo_count)
    );

    assign a_tdata = head[A_WORD_W-1:0];
    assign a_tlast = head[A_WORD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wave_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ext_start <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wave_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                // Room is reserved before issuing, so the later push can
                // never land on a full FIFO.
                S_ISSUE: begin
                    if (fifo_count < DEPTH_C) begin
                        ext_start <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    ext_start <= 1'b0;
                    if (ext_valid) begin
                        if (wave_cnt == LAST_WAVE) begin
                            state <= S_DRAIN;
                        end else begin
                            wave_cnt <= wave_cnt + 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                // Finish on the edge that retires the final word, so done
                // appears the cycle right after that pop.
                S_DRAIN: begin
                    if (fifo_count == '0 || (fifo_count == CW'(1) && pop)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef A_FEED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            stall_cycles <= '0;
            issue_stalls <= '0;
        end else begin
            if (busy && a_tvalid && !a_tready && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (state == S_ISSUE && fifo_count >= DEPTH_C && issue_stalls != 16'hFFFF)
                issue_stalls <= issue_stalls + 16'd1;
        end
    end
`endif

    // A response strobe with no extraction outstanding is an extractor bug.
    a_ext_valid_in_wait: assert property (
        @(posedge clk) disable iff (rst) ext_valid |-> (state == S_WAIT)
    );

endmodule
